usb_ep_buf_arb: RTL and testbench

Two-requester arbiter that shares the endpoint packet buffer's independent read and write ports between the USB core (port 0) and the system-bus / CPU side (port 1). Each buffer port is arbitrated separately, with round-robin or fixed priority and optional burst locking. Read data is returned with a routed one-cycle-latency valid strobe. The block sits directly between the endpoint buffer RAM and its two users.

---
 rtl/usb_ep_buf_arb.sv | 132 +++++++++++++
 tb/tb_usb_ep_buf_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_buf_arb.sv
// Two-port arbiter in front of the endpoint buffer RAM: independent read and write arbiters, RR or FIXED0.
// Grant, ack and buffer enable are combinational; read valid lags the ack by one cycle; the losing port holds req.
module usb_ep_buf_arb #(
   parameter string PRIO   = "RR",
   parameter int    RWIDTH = 8,
   parameter int    WWIDTH = 8,
   parameter int    ARW    = 11,
   parameter int    AWW    = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd0_req,
   input  logic              rd0_lock,
   input  logic [ARW-1:0]    rd0_addr,
   output logic              rd0_ack,
   output logic              rd0_valid,
   input  logic              rd1_req,
   input  logic              rd1_lock,
   input  logic [ARW-1:0]    rd1_addr,
   output logic              rd1_ack,
   output logic              rd1_valid,
   output logic [RWIDTH-1:0] rd_data,
   input  logic              wr0_req,
   input  logic              wr0_lock,
   input  logic [AWW-1:0]    wr0_addr,
   input  logic [WWIDTH-1:0] wr0_data,
   output logic              wr0_ack,
   input  logic              wr1_req,
   input  logic              wr1_lock,
   input  logic [AWW-1:0]    wr1_addr,
   input  logic [WWIDTH-1:0] wr1_data,
   output logic              wr1_ack,
   output logic [ARW-1:0]    buf_rd_addr_0,
   output logic              buf_rd_en_0,
   input  logic [RWIDTH-1:0] buf_rd_data_1,
   output logic [AWW-1:0]    buf_wr_addr_0,
   output logic [WWIDTH-1:0] buf_wr_data_0,
   output logic              buf_wr_en_0
);

   localparam bit FIXED0 = (PRIO == "FIXED0");

   typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

   // index 0 arbitrates the read port, index 1 the write port
   logic [1:0] arb_req  [2];
   logic [1:0] arb_lock [2];
   logic       gnt      [2];
   logic       idx      [2];

   assign arb_req[0]  = {rd1_req,  rd0_req};
   assign arb_lock[0] = {rd1_lock, rd0_lock};
   assign arb_req[1]  = {wr1_req,  wr0_req};
   assign arb_lock[1] = {wr1_lock, wr0_lock};

   for (genvar a = 0; a < 2; a++) begin : g_arb
      owner_t owner, owner_nxt;
      logic   last, last_nxt;

      always_ff @(posedge clk) begin
         if (rst) begin
            owner <= OWN_NONE;
            last  <= 1'b1;
         end else begin
            owner <= owner_nxt;
            last  <= last_nxt;
         end
      end

      // a lock holder that drops req loses ownership and normal arbitration runs this same cycle
      always_comb begin
         gnt[a]    = 1'b0;
         idx[a]    = 1'b0;
         owner_nxt = OWN_NONE;
         last_nxt  = last;
         if (owner == OWN_P0 && arb_req[a][0]) begin
            gnt[a] = 1'b1;
            idx[a] = 1'b0;
         end else if (owner == OWN_P1 && arb_req[a][1]) begin
            gnt[a] = 1'b1;
            idx[a] = 1'b1;
         end else if (arb_req[a] == 2'b11) begin
            gnt[a] = 1'b1;
            idx[a] = FIXED0 ? 1'b0 : ~last;
         end else if (arb_req[a][0]) begin
            gnt[a] = 1'b1;
            idx[a] = 1'b0;
         end else if (arb_req[a][1]) begin
            gnt[a] = 1'b1;
            idx[a] = 1'b1;
         end
         if (rst) begin
            gnt[a] = 1'b0;
         end
         if (gnt[a]) begin
            last_nxt = idx[a];
            if (arb_lock[a][idx[a]]) begin
               owner_nxt = idx[a] ? OWN_P1 : OWN_P0;
            end
         end
      end
   end

   assign rd0_ack       = gnt[0] & ~idx[0];
   assign rd1_ack       = gnt[0] &  idx[0];
   assign buf_rd_en_0   = gnt[0];
   assign buf_rd_addr_0 = idx[0] ? rd1_addr : rd0_addr;

   assign wr0_ack       = gnt[1] & ~idx[1];
   assign wr1_ack       = gnt[1] &  idx[1];
   assign buf_wr_en_0   = gnt[1];
   assign buf_wr_addr_0 = idx[1] ? wr1_addr : wr0_addr;
   assign buf_wr_data_0 = idx[1] ? wr1_data : wr0_data;

   logic rd_pend;
   logic rd_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= buf_rd_en_0;
      end
      rd_sel <= idx[0];
   end

   // gating with rst kills the return of a read acked just before reset
   assign rd0_valid = rd_pend & ~rst & ~rd_sel;
   assign rd1_valid = rd_pend & ~rst &  rd_sel;
   assign rd_data   = buf_rd_data_1;

endmodule

// File: tb/tb_usb_ep_buf_arb.sv
// Scoreboard bench: an RR and a FIXED0 instance share stimulus; a reference model predicts acks and read returns.
module tb_usb_ep_buf_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        rd0_req = 0, rd0_lock = 0, rd1_req = 0, rd1_lock = 0;
   logic [10:0] rd0_addr = 0, rd1_addr = 0;
   logic        wr0_req = 0, wr0_lock = 0, wr1_req = 0, wr1_lock = 0;
   logic [10:0] wr0_addr = 0, wr1_addr = 0;
   logic [7:0]  wr0_data = 0, wr1_data = 0;

   logic        rd0_ack, rd1_ack, rd0_valid, rd1_valid, wr0_ack, wr1_ack;
   logic [7:0]  rd_data;
   logic [10:0] buf_rd_addr_0, buf_wr_addr_0;
   logic        buf_rd_en_0, buf_wr_en_0;
   logic [7:0]  buf_wr_data_0;
   logic [7:0]  ram_q;

   logic        f_rd0_ack, f_rd1_ack, f_rd0_valid, f_rd1_valid, f_wr0_ack, f_wr1_ack;
   logic [7:0]  f_rd_data;
   logic [10:0] f_buf_rd_addr_0, f_buf_wr_addr_0;
   logic        f_buf_rd_en_0, f_buf_wr_en_0;
   logic [7:0]  f_buf_wr_data_0;

   usb_ep_buf_arb #(.PRIO("RR")) dut (
      .clk(clk), .rst(rst),
      .rd0_req(rd0_req), .rd0_lock(rd0_lock), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack), .rd0_valid(rd0_valid),
      .rd1_req(rd1_req), .rd1_lock(rd1_lock), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack), .rd1_valid(rd1_valid),
      .rd_data(rd_data),
      .wr0_req(wr0_req), .wr0_lock(wr0_lock), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
      .wr1_req(wr1_req), .wr1_lock(wr1_lock), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
      .buf_rd_addr_0(buf_rd_addr_0), .buf_rd_en_0(buf_rd_en_0), .buf_rd_data_1(ram_q),
      .buf_wr_addr_0(buf_wr_addr_0), .buf_wr_data_0(buf_wr_data_0), .buf_wr_en_0(buf_wr_en_0)
   );

   usb_ep_buf_arb #(.PRIO("FIXED0")) dut_fx (
      .clk(clk), .rst(rst),
      .rd0_req(rd0_req), .rd0_lock(rd0_lock), .rd0_addr(rd0_addr), .rd0_ack(f_rd0_ack), .rd0_valid(f_rd0_valid),
      .rd1_req(rd1_req), .rd1_lock(rd1_lock), .rd1_addr(rd1_addr), .rd1_ack(f_rd1_ack), .rd1_valid(f_rd1_valid),
      .rd_data(f_rd_data),
      .wr0_req(wr0_req), .wr0_lock(wr0_lock), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(f_wr0_ack),
      .wr1_req(wr1_req), .wr1_lock(wr1_lock), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(f_wr1_ack),
      .buf_rd_addr_0(f_buf_rd_addr_0), .buf_rd_en_0(f_buf_rd_en_0), .buf_rd_data_1(ram_q),
      .buf_wr_addr_0(f_buf_wr_addr_0), .buf_wr_data_0(f_buf_wr_data_0), .buf_wr_en_0(f_buf_wr_en_0)
   );

   function automatic logic [7:0] init_val(int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   // buffer RAM driven by the RR instance
   logic [7:0] ram [0:2047];
   bit ram_inited;
   always @(posedge clk) begin
      if (!ram_inited) begin
         for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
         ram_inited <= 1'b1;
      end else begin
         if (buf_rd_en_0) ram_q <= ram[buf_rd_addr_0];
         if (buf_wr_en_0) ram[buf_wr_addr_0] <= buf_wr_data_0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit rst; bit [1:0] rreq, rlock, wreq, wlock;
      bit [10:0] ra0, ra1, wa0, wa1; bit [7:0] wd0, wd1;
   } stim_t;
   typedef struct {
      bit [1:0] rd_ack, wr_ack, f_rd_ack, f_wr_ack;
      bit rd_en, wr_en; bit [10:0] rd_addr, wr_addr; bit [7:0] wr_data;
   } exp_t;
   typedef struct { int due; bit port; bit [7:0] data; } rexp_t;

   exp_t  exp_q[$];
   rexp_t rd_q[$];
   int total = 0;
   int bad = 0;
   bit [7:0] mdl_mem [2048];
   int m_last  [4];
   int m_owner [4];   // -1: no lock holder

   function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
      end
   endfunction

   // arbiter k: 0 = RR read, 1 = RR write, 2 = FIXED0 read, 3 = FIXED0 write
   function automatic void arb(int k, bit fixed0, bit [1:0] req, bit [1:0] lock, output bit g, output bit w);
      int winner = -1;
      if (m_owner[k] >= 0 && req[m_owner[k]]) winner = m_owner[k];
      else if (req == 2'b11) winner = fixed0 ? 0 : 1 - m_last[k];
      else if (req == 2'b01) winner = 0;
      else if (req == 2'b10) winner = 1;
      g = (winner >= 0);
      w = (winner == 1);
      if (g) begin
         m_last[k]  = winner;
         m_owner[k] = lock[winner] ? winner : -1;
      end else begin
         m_owner[k] = -1;
      end
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit g, w;
      bit [10:0] a;
      @(posedge clk);
      #1;
      rst = s.rst;
      {rd1_req, rd0_req} = s.rreq;  {rd1_lock, rd0_lock} = s.rlock;
      {wr1_req, wr0_req} = s.wreq;  {wr1_lock, wr0_lock} = s.wlock;
      rd0_addr = s.ra0; rd1_addr = s.ra1;
      wr0_addr = s.wa0; wr1_addr = s.wa1; wr0_data = s.wd0; wr1_data = s.wd1;
      e = '{default: 0};
      if (s.rst) begin
         for (int k = 0; k < 4; k++) begin m_last[k] = 1; m_owner[k] = -1; end
         while (rd_q.size() > 0 && rd_q[$].due == cyc) void'(rd_q.pop_back());
      end else begin
         arb(0, 1'b0, s.rreq, s.rlock, g, w);
         if (g) begin
            a = w ? s.ra1 : s.ra0;
            e.rd_ack[w] = 1'b1; e.rd_en = 1'b1; e.rd_addr = a;
            rd_q.push_back('{cyc + 1, w, mdl_mem[a]});
         end
         arb(1, 1'b0, s.wreq, s.wlock, g, w);
         if (g) begin
            a = w ? s.wa1 : s.wa0;
            e.wr_ack[w] = 1'b1; e.wr_en = 1'b1; e.wr_addr = a;
            e.wr_data = w ? s.wd1 : s.wd0;
            mdl_mem[a] = e.wr_data;
         end
         arb(2, 1'b1, s.rreq, s.rlock, g, w);
         if (g) e.f_rd_ack[w] = 1'b1;
         arb(3, 1'b1, s.wreq, s.wlock, g, w);
         if (g) e.f_wr_ack[w] = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   // monitor: compares every cycle at the falling edge
   initial begin
      exp_t  e;
      rexp_t r;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_ack", 32'({rd1_ack, rd0_ack}), 32'(e.rd_ack));
            chk("wr_ack", 32'({wr1_ack, wr0_ack}), 32'(e.wr_ack));
            chk("buf_rd_en", 32'(buf_rd_en_0), 32'(e.rd_en));
            chk("buf_wr_en", 32'(buf_wr_en_0), 32'(e.wr_en));
            if (e.rd_en) chk("buf_rd_addr", 32'(buf_rd_addr_0), 32'(e.rd_addr));
            if (e.wr_en) begin
               chk("buf_wr_addr", 32'(buf_wr_addr_0), 32'(e.wr_addr));
               chk("buf_wr_data", 32'(buf_wr_data_0), 32'(e.wr_data));
            end
            chk("fx_rd_ack", 32'({f_rd1_ack, f_rd0_ack}), 32'(e.f_rd_ack));
            chk("fx_wr_ack", 32'({f_wr1_ack, f_wr0_ack}), 32'(e.f_wr_ack));
         end
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r = rd_q.pop_front();
            chk("rd_valid", 32'({rd1_valid, rd0_valid}), r.port ? 32'd2 : 32'd1);
            chk("rd_data", 32'(rd_data), 32'(r.data));
         end else begin
            chk("rd_valid_idle", 32'({rd1_valid, rd0_valid}), 32'd0);
         end
      end
   end

   initial begin
      stim_t s;
      for (int i = 0; i < 2048; i++) mdl_mem[i] = init_val(i);
      for (int k = 0; k < 4; k++) begin m_last[k] = 1; m_owner[k] = -1; end

      // reset with every port requesting
      s = '{default: 0};
      s.rst = 1; s.rreq = 2'b11; s.wreq = 2'b11;
      repeat (3) step(s);

      // round-robin alternation on the read port
      s = '{default: 0};
      s.rreq = 2'b11; s.ra0 = 11'h010; s.ra1 = 11'h020;
      repeat (6) step(s);

      // locked write burst from port 1, then port 0 gets in
      s = '{default: 0};
      s.wa0 = 11'h040; s.wd0 = 8'h55;
      for (int k = 0; k < 4; k++) begin
         s.wreq  = (k == 0) ? 2'b10 : 2'b11;
         s.wlock = (k == 3) ? 2'b00 : 2'b10;
         s.wa1 = 11'(11'h100 + k);
         s.wd1 = 8'(8'hA0 + k);
         step(s);
      end
      s.wlock = 2'b00;
      step(s);

      // lock holder drops req
      s = '{default: 0};
      s.ra0 = 11'h003; s.ra1 = 11'h004;
      s.rreq = 2'b01; s.rlock = 2'b01; step(s);
      s.rreq = 2'b11; step(s);
      s.rreq = 2'b10; s.rlock = 2'b00; step(s);

      // read and write to the same address in the same cycle
      s = '{default: 0};
      s.wreq = 2'b01; s.wa0 = 11'h005; s.wd0 = 8'h11; step(s);
      s.rreq = 2'b01; s.ra0 = 11'h005; s.wd0 = 8'h22; step(s);
      s.wreq = 2'b00; step(s);

      // reset during a locked read burst owned by port 1
      s = '{default: 0};
      s.ra0 = 11'h007; s.ra1 = 11'h008;
      s.rreq = 2'b10; s.rlock = 2'b10; step(s);
      s.rreq = 2'b11; step(s); step(s);
      s.rst = 1; step(s);
      s.rst = 0; s.rlock = 2'b00; step(s); step(s);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         s.rst   = ($urandom_range(0, 99) == 0);
         s.rreq  = 2'($urandom);
         s.wreq  = 2'($urandom);
         s.rlock = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         s.wlock = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         s.ra0 = 11'($urandom_range(0, 31)); s.ra1 = 11'($urandom_range(0, 31));
         s.wa0 = 11'($urandom_range(0, 31)); s.wa1 = 11'($urandom_range(0, 31));
         s.wd0 = 8'($urandom); s.wd1 = 8'($urandom);
         step(s);
      end

      s = '{default: 0};
      repeat (2) step(s);
      repeat (2) @(negedge clk);
      chk("read_returns_outstanding", 32'(rd_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
